vga_timing_rx: RTL and testbench
================================

Name: vga_timing_rx

Overview:
- Receive-side counterpart of the VGA timing generator: consumes HS/VS/BLANK_N/RGB as driven onto the VGA pins and recovers pixel coordinates, line/frame pulses and pixel data.
- Checks the stream against nominal timing and reports lock and errors.
- Used in loopback self-test and as the front end of the frame-grab path, on the 25 MHz pixel clock.

Parameters:
H_ACTIVE, 640, active pixels per line
H_TOTAL, 800, pixel clocks per line (HS edge to HS edge)
V_ACTIVE, 480, active lines per frame
V_TOTAL, 525, lines per frame (HS edges per VS period)
SYNC_NEG, 1, 1 = HS/VS active-low, 0 = active-high
CORDW, 16, coordinate width

Ports:
i_clk_25  in  1  pixel clock
i_rst_n  in  1  reset, asynchronous, active-low
i_hs  in  1  horizontal sync, polarity per SYNC_NEG
i_vs  in  1  vertical sync, polarity per SYNC_NEG
i_blank_n  in  1  1 = active video (de)
i_r, i_g, i_b  in  8 each  pixel colour
o_r, o_g, o_b  out  8 each  registered pixel colour
o_x  out  CORDW  active-pixel column of current output pixel
o_y  out  CORDW  active-line row of current output pixel
o_pix_valid  out  1  o_r/g/b and o_x/o_y valid
o_line_start  out  1  1-cycle pulse on HS assert edge, only when locked
o_frame_start  out  1  1-cycle pulse on VS assert edge, only when locked
o_locked  out  1  1 in LOCKED state
o_err  out  1  1-cycle pulse on any timing violation, CHECK or LOCKED only
o_err_cnt  out  8  saturating violation count (stops at 255)

Behaviour:
- Clock and reset: one clock (i_clk_25); reset asynchronous, active-low (i_rst_n). Reset clears all outputs and counters to 0 and sets the state to SEARCH. Reset mid-frame restarts acquisition.
- Input stage: all inputs registered once (stage 1). hs_act = SYNC_NEG ? ~hs : hs, same rule for vs.
- Edge detection: assert edges are 0->1 of hs_act/vs_act, detected on stage-1 versus the previous stage-1 value.
- Output stage: stage 2 registers o_r/g/b, o_x, o_y, o_pix_valid.
  - Input-to-output latency is exactly 2 cycles.
  - o_pix_valid = stage-1 de AND state==LOCKED.
  - o_r/g/b are 0 whenever o_pix_valid=0.
- Pulse alignment: o_line_start and o_frame_start are registered, asserting 2 cycles after the input edge (aligned with the output stage).
- h_clk: cleared to 0 on the HS edge cycle, +1 otherwise, saturating at 2^12-1.
  - Violation if an HS edge arrives with h_clk != H_TOTAL-1.
  - Violation if h_clk reaches H_TOTAL with no edge; this is reported once, then h_clk saturates silently.
- de_cnt: counts de cycles since the last HS edge.
  - At each HS edge, violation if de_cnt is nonzero and != H_ACTIVE. Then de_cnt clears.
- Column: o_x clears on the de rising edge and increments per de cycle, so it spans 0..H_ACTIVE-1.
- Row: o_y increments on each de falling edge and clears on the VS edge.
- v_cnt: counts HS edges since the last VS edge. An HS edge in the same cycle as the VS edge counts toward the closing frame.
  - At the VS edge, violation if (v_cnt + coincident HS) != V_TOTAL.
  - At the VS edge, violation if the number of lines with de > 0 != V_ACTIVE.
  - After the check, v_cnt and the active-line count clear.
- Coincident violations: multiple violations in one cycle produce one o_err pulse and +1 to o_err_cnt.
- State machine:
  - SEARCH: no checks, no errors reported, outputs invalid. First VS edge -> CHECK, and counters start from this edge.
  - CHECK: checks active. Any violation -> SEARCH. Next VS edge with no violation in the frame, including the VS-edge checks themselves -> LOCKED.
  - LOCKED: o_locked=1. Any violation -> SEARCH. o_locked drops the cycle after the violation cycle; o_err pulses in that same cycle.
- o_err_cnt holds across state changes; it clears only on reset.

Test Plan:
Small params (H_ACTIVE=8, H_TOTAL=16, V_ACTIVE=4, V_TOTAL=8, SYNC_NEG=1) unless stated.
1. Nominal stream from first VS -> o_locked=1 after second VS edge (+1 cycle); o_err_cnt=0; o_pix_valid pulses 8 per active line, 4 lines; o_x 0..7, o_y 0..3; o_r/g/b equals input delayed exactly 2 cycles.
2. Locked, one line with 17 clocks between HS edges -> o_err pulses once, o_err_cnt=1, o_locked=0, o_pix_valid=0. Then relocks after two clean VS edges.
3. Locked, de held 7 cycles on one line -> single o_err at that line's next HS edge; state SEARCH.
4. HS stuck inactive -> exactly one o_err when h_clk reaches 16; o_err_cnt=1, not incrementing further while stuck.
5. Frame with 9 HS edges, one coincident with VS -> o_err at VS edge. Repeat with a frame of 8 edges -> no error.
6. Assert i_rst_n=0 mid-active-line while locked -> all outputs 0 immediately (async), state SEARCH; after release, lock needs two VS edges. Also 300 forced violations -> o_err_cnt saturates at 255.

Source files
------------

// File: rtl/vga_timing_rx.sv
// VGA receive-side timing recovery: registers the pin-level stream, recovers
// pixel coordinates and line/frame pulses, and checks timing to report lock.
`timescale 1ns/1ps

module vga_timing_rx #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter bit SYNC_NEG = 1'b1,
    parameter int CORDW    = 16
) (
    input  logic             i_clk_25,
    input  logic             i_rst_n,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic             i_blank_n,
    input  logic [7:0]       i_r,
    input  logic [7:0]       i_g,
    input  logic [7:0]       i_b,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b,
    output logic [CORDW-1:0] o_x,
    output logic [CORDW-1:0] o_y,
    output logic             o_pix_valid,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic             o_locked,
    output logic             o_err,
    output logic [7:0]       o_err_cnt
);

    localparam int CW = 12;
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_OVER  = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_ACT_W = CW'(H_ACTIVE);
    localparam logic [CW:0]   V_TOT_W = (CW+1)'(V_TOTAL);
    localparam logic [CW:0]   V_ACT_W = (CW+1)'(V_ACTIVE);
    localparam logic [CW-1:0] SAT     = '1;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t state, state_nxt;

    logic             hs1, vs1, de1, hs_prev, vs_prev, de_prev;
    logic [7:0]       r1, g1, b1;
    logic [CW-1:0]    h_clk, de_cnt, v_cnt, act_cnt;
    logic [CORDW-1:0] x_cnt, y_cnt, cur_x;
    logic             hs_act, vs_act, hs_edge, vs_edge, de_rise, de_fall;
    logic             line_seen, viol, is_locked;
    logic [CW:0]      v_seen, a_seen;

    // Stage 1 resets to the inactive sync level so release never fakes an edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs1     <= SYNC_NEG;
            vs1     <= SYNC_NEG;
            de1     <= 1'b0;
            r1      <= '0;
            g1      <= '0;
            b1      <= '0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            de_prev <= 1'b0;
        end else begin
            hs1     <= i_hs;
            vs1     <= i_vs;
            de1     <= i_blank_n;
            r1      <= i_r;
            g1      <= i_g;
            b1      <= i_b;
            hs_prev <= hs_act;
            vs_prev <= vs_act;
            de_prev <= de1;
        end
    end

    assign hs_act    = SYNC_NEG ? ~hs1 : hs1;
    assign vs_act    = SYNC_NEG ? ~vs1 : vs1;
    assign hs_edge   = hs_act & ~hs_prev;
    assign vs_edge   = vs_act & ~vs_prev;
    assign de_rise   = de1 & ~de_prev;
    assign de_fall   = ~de1 & de_prev;
    assign cur_x     = de_rise ? '0 : x_cnt;
    assign is_locked = (state == LOCKED);
    assign o_locked  = is_locked;

    // A line closing on the VS edge still belongs to the frame being checked.
    assign line_seen = hs_edge && (de_cnt != '0);
    assign v_seen    = {1'b0, v_cnt} + {{CW{1'b0}}, hs_edge};
    assign a_seen    = {1'b0, act_cnt} + {{CW{1'b0}}, line_seen};

    assign viol = (state != SEARCH) && (
                     (hs_edge && (h_clk != H_LAST))
                  || (!hs_edge && (h_clk == H_OVER))
                  || (line_seen && (de_cnt != H_ACT_W))
                  || (vs_edge && ((v_seen != V_TOT_W) || (a_seen != V_ACT_W))));

    // NOTE: next state is defaulted first so no path leaves it unassigned,
    // which keeps this block purely combinational (no inferred latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            SEARCH: if (vs_edge) state_nxt = CHECK;
            CHECK:  if (viol) state_nxt = SEARCH;
                    else if (vs_edge) state_nxt = LOCKED;
            LOCKED: if (viol) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= SEARCH;
            h_clk   <= '0;
            de_cnt  <= '0;
            v_cnt   <= '0;
            act_cnt <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            h_clk   <= hs_edge ? '0 : (h_clk == SAT) ? h_clk : h_clk + 1'b1;
            if (hs_edge)
                de_cnt <= {{(CW-1){1'b0}}, de1};
            else if (de1 && de_cnt != SAT)
                de_cnt <= de_cnt + 1'b1;
            if (vs_edge)
                v_cnt <= '0;
            else if (hs_edge && v_cnt != SAT)
                v_cnt <= v_cnt + 1'b1;
            if (vs_edge)
                act_cnt <= '0;
            else if (line_seen && act_cnt != SAT)
                act_cnt <= act_cnt + 1'b1;
            if (de1)
                x_cnt <= cur_x + 1'b1;
            if (vs_edge)
                y_cnt <= '0;
            else if (de_fall)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    // Stage 2: everything here lines up with the pixel that entered two cycles ago.
    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_pix_valid   <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_err         <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            o_pix_valid   <= de1 && is_locked;
            o_r           <= (de1 && is_locked) ? r1 : '0;
            o_g           <= (de1 && is_locked) ? g1 : '0;
            o_b           <= (de1 && is_locked) ? b1 : '0;
            o_x           <= (de1 && is_locked) ? cur_x : '0;
            o_y           <= (de1 && is_locked) ? y_cnt : '0;
            o_line_start  <= hs_edge && is_locked;
            o_frame_start <= vs_edge && is_locked;
            o_err         <= viol;
            if (viol && o_err_cnt != 8'hFF)
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx with small timing parameters: lock, pixel
// path, each timing violation class, async reset and error-count saturation.
`timescale 1ns/1ps

module tb_vga_timing_rx;

    localparam int CORDW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hs = 1'b1, vs = 1'b1, blank_n = 1'b0;
    logic [7:0]       r = '0, g = '0, b = '0;
    logic [7:0]       o_r, o_g, o_b, o_err_cnt;
    logic [CORDW-1:0] o_x, o_y;
    logic             o_pix_valid, o_line_start, o_frame_start, o_locked, o_err;

    vga_timing_rx #(
        .H_ACTIVE(8), .H_TOTAL(16), .V_ACTIVE(4), .V_TOTAL(8),
        .SYNC_NEG(1'b1), .CORDW(CORDW)
    ) dut (
        .i_clk_25(clk), .i_rst_n(rst_n),
        .i_hs(hs), .i_vs(vs), .i_blank_n(blank_n),
        .i_r(r), .i_g(g), .i_b(b),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_x(o_x), .o_y(o_y), .o_pix_valid(o_pix_valid),
        .o_line_start(o_line_start), .o_frame_start(o_frame_start),
        .o_locked(o_locked), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic       de;
        logic [7:0] r, g, b;
        logic [15:0] x, y;
    } pix_t;

    int   checks = 0, errors = 0;
    int   cyc = 0, err_cyc = -1, locked_cyc = -1, vs_cyc = -1;
    int   n_valid = 0, n_err = 0, n_ls = 0, n_fs = 0;
    int   line_cyc[16];
    bit   chk_pix = 1'b0;
    logic locked_q = 1'b0, vs_last = 1'b1;
    pix_t p1 = '0, p2 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample outputs at the falling edge, then drive the next input vector.
    task automatic tick(input logic t_hs, input logic t_vs, input logic t_de,
                        input logic [7:0] t_r, input logic [7:0] t_g, input logic [7:0] t_b,
                        input logic [15:0] t_x, input logic [15:0] t_y);
        @(negedge clk);
        cyc++;
        if (o_pix_valid) n_valid++;
        if (o_line_start) n_ls++;
        if (o_frame_start) n_fs++;
        if (o_err) begin n_err++; err_cyc = cyc; end
        if (o_locked && !locked_q) locked_cyc = cyc;
        locked_q = o_locked;
        if (chk_pix) begin
            check("pix_valid", o_pix_valid, p2.de);
            check("pix_r", o_r, p2.de ? p2.r : 8'h00);
            check("pix_g", o_g, p2.de ? p2.g : 8'h00);
            check("pix_b", o_b, p2.de ? p2.b : 8'h00);
            if (p2.de) begin
                check("pix_x", o_x, p2.x);
                check("pix_y", o_y, p2.y);
            end
        end
        hs = t_hs; vs = t_vs; blank_n = t_de; r = t_r; g = t_g; b = t_b;
        if (!t_vs && vs_last) vs_cyc = cyc;
        vs_last = t_vs;
        p2 = p1;
        p1 = '{de: t_de, r: t_r, g: t_g, b: t_b, x: t_x, y: t_y};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0);
    endtask

    // HS low cols 0-1, de cols 4..4+de_len-1 on lines 0-3, VS low on lines 5-6.
    task automatic run_line(input int l, input int len, input int de_len);
        logic [7:0] pv;
        line_cyc[l] = cyc + 1;
        for (int c = 0; c < len; c++) begin
            pv = 8'(l * 16 + c);
            tick(c >= 2, !(l == 5 || l == 6), (l < 4) && c >= 4 && c < 4 + de_len,
                 pv, ~pv, pv ^ 8'h5A, 16'(c - 4), 16'(l));
        end
    endtask

    task automatic run_frame(input int n_lines, input int odd_line, input int odd_len, input int odd_de);
        for (int l = 0; l < n_lines; l++)
            run_line(l, (l == odd_line) ? odd_len : 16, (l == odd_line) ? odd_de : 8);
    endtask

    task automatic clear_counts();
        n_valid = 0; n_err = 0; n_ls = 0; n_fs = 0; err_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(3);
        check("rst_locked", o_locked, 0);
        check("rst_err_cnt", o_err_cnt, 0);
        check("rst_pix_valid", o_pix_valid, 0);
        check("rst_line_start", o_line_start, 0);
        rst_n = 1'b1;
        p1 = '0; p2 = '0; locked_q = 1'b0; vs_last = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        do_reset();

        // Nominal acquisition: first VS -> CHECK, second VS -> LOCKED.
        run_frame(8, -1, 16, 8);
        check("t1_unlocked_first_frame", o_locked, 0);
        run_frame(8, -1, 16, 8);
        check("t1_locked", o_locked, 1);
        check("t1_lock_time", locked_cyc, vs_cyc + 2);
        clear_counts();
        chk_pix = 1'b1;
        run_frame(8, -1, 16, 8);
        chk_pix = 1'b0;
        check("t1_valid_count", n_valid, 32);
        check("t1_line_starts", n_ls, 8);
        check("t1_frame_starts", n_fs, 1);
        check("t1_no_err", n_err, 0);
        check("t1_err_cnt", o_err_cnt, 0);

        // 17-clock line: error at the following HS edge, then relock.
        clear_counts();
        run_frame(8, 2, 17, 8);
        check("t2_err_pulses", n_err, 1);
        check("t2_err_time", err_cyc, line_cyc[3] + 2);
        check("t2_err_cnt", o_err_cnt, 1);
        check("t2_unlocked", o_locked, 0);
        check("t2_valid_count", n_valid, 24);
        run_frame(8, -1, 16, 8);
        check("t2_relocked", o_locked, 1);
        check("t2_err_cnt_hold", o_err_cnt, 1);

        // Short de on line 1: error reported at line 2's HS edge.
        clear_counts();
        run_frame(8, 1, 16, 7);
        check("t3_err_pulses", n_err, 1);
        check("t3_err_time", err_cyc, line_cyc[2] + 2);
        check("t3_err_cnt", o_err_cnt, 2);
        check("t3_unlocked", o_locked, 0);

        // HS stuck inactive while locked: exactly one timeout error.
        do_reset();
        run_frame(8, -1, 16, 8);
        run_frame(8, -1, 16, 8);
        check("t4_locked", o_locked, 1);
        clear_counts();
        idle(80);
        check("t4_err_pulses", n_err, 1);
        check("t4_err_time", err_cyc, line_cyc[7] + 19);
        check("t4_err_cnt", o_err_cnt, 1);
        check("t4_unlocked", o_locked, 0);

        // Nine HS edges between VS edges: error on the closing VS edge.
        run_frame(8, -1, 16, 8);
        run_frame(8, -1, 16, 8);
        check("t5_locked", o_locked, 1);
        clear_counts();
        run_frame(9, -1, 16, 8);
        check("t5_no_err_yet", n_err, 0);
        run_frame(8, -1, 16, 8);
        check("t5_err_pulses", n_err, 1);
        check("t5_err_time", err_cyc, line_cyc[5] + 2);
        check("t5_err_cnt", o_err_cnt, 2);
        check("t5_unlocked", o_locked, 0);
        clear_counts();
        run_frame(8, -1, 16, 8);
        run_frame(8, -1, 16, 8);
        run_frame(8, -1, 16, 8);
        check("t5_clean_no_err", n_err, 0);
        check("t5_clean_locked", o_locked, 1);

        // Asynchronous reset in the middle of an active line.
        for (int c = 0; c < 9; c++)
            tick(c >= 2, 1'b1, c >= 4, 8'(c), 8'(~c), 8'(c ^ 8'h5A), 16'(c - 4), 16'h0);
        check("t6_pre_valid", o_pix_valid, 1);
        #5 rst_n = 1'b0;
        #1;
        check("t6_async_valid", o_pix_valid, 0);
        check("t6_async_r", o_r, 0);
        check("t6_async_x", o_x, 0);
        check("t6_async_locked", o_locked, 0);
        check("t6_async_err_cnt", o_err_cnt, 0);
        do_reset();
        run_frame(8, -1, 16, 8);
        check("t6_one_vs_unlocked", o_locked, 0);
        run_frame(8, -1, 16, 8);
        check("t6_relocked", o_locked, 1);

        // Rapid VS pulses with no lines force repeated violations.
        clear_counts();
        for (int i = 0; i < 620; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0);
            tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0);
            tick(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0);
            tick(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0);
        end
        idle(4);
        check("t6_err_pulses_many", n_err >= 300, 1);
        check("t6_err_cnt_sat", o_err_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
